// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per channel.
// Optional DEMUX_DROP_CNT_EN adds a saturating count of discarded out-of-range words.
module demux_1ton_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [SELW-1:0]      in_sel_i,
   input  logic [WIDTH-1:0]     in_data_i,
   output logic [N-1:0]         out_valid_o,
   input  logic [N-1:0]         out_ready_i,
   output logic [N*WIDTH-1:0]   out_data_o,
`ifdef DEMUX_DROP_CNT_EN
   output logic [15:0]          drop_cnt_o,
`endif
   output logic                 err_sel_o
);

   localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

   logic [N-1:0]       v_q, v_d;
   logic [N*WIDTH-1:0] data_q, data_d;
   logic               err_q, err_d;
   logic               in_range_s;
   logic               in_ready_s;
   logic               drop_s;

   assign in_range_s = ({1'b0, in_sel_i} < NUM_CH);

   // Readiness depends only on select, consumer ready and holding state.
   always_comb begin
      in_ready_s = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (in_range_s && (in_sel_i == SELW'(k))) begin
            in_ready_s = ~v_q[k] | out_ready_i[k];
         end else begin
            in_ready_s = in_ready_s;
         end
      end
   end

   assign drop_s = in_valid_i & in_ready_s & ~in_range_s;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      err_d  = err_q | drop_s;
      for (int k = 0; k < N; k++) begin
         if (v_q[k] && out_ready_i[k]) begin
            v_d[k] = 1'b0;
         end else begin
            v_d[k] = v_d[k];
         end
         // A load on the same edge as a drain wins, so the channel stays full.
         if (in_valid_i && in_ready_s && in_range_s && (in_sel_i == SELW'(k))) begin
            v_d[k]                = 1'b1;
            data_d[k*WIDTH +: WIDTH] = in_data_i;
         end else begin
            data_d[k*WIDTH +: WIDTH] = data_d[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q    <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

`ifdef DEMUX_DROP_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      if (drop_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign drop_cnt_o = cnt_q;
`endif

   assign in_ready_o  = in_ready_s;
   assign out_valid_o = v_q;
   assign out_data_o  = data_q;
   assign err_sel_o   = err_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream: a 4-channel instance and a 3-channel instance
// (the latter exercises out-of-range selects). Honors DEMUX_DROP_CNT_EN.
module tb_demux_1ton_stream;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        v4, rdy4;
   logic [1:0]  sel4;
   logic [7:0]  dat4;
   logic [3:0]  ov4, or4;
   logic [31:0] od4;
   logic        err4;

   logic        v3, rdy3;
   logic [1:0]  sel3;
   logic [7:0]  dat3;
   logic [2:0]  ov3, or3;
   logic [23:0] od3;
   logic        err3;
`ifdef DEMUX_DROP_CNT_EN
   logic [15:0] dc4, dc3;
`endif

   demux_1ton_stream #(.WIDTH(8), .N(4), .SELW(2)) dut4 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(rdy4),
      .in_sel_i(sel4), .in_data_i(dat4), .out_valid_o(ov4), .out_ready_i(or4),
      .out_data_o(od4),
`ifdef DEMUX_DROP_CNT_EN
      .drop_cnt_o(dc4),
`endif
      .err_sel_o(err4));

   demux_1ton_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(v3), .in_ready_o(rdy3),
      .in_sel_i(sel3), .in_data_i(dat3), .out_valid_o(ov3), .out_ready_i(or3),
      .out_data_o(od3),
`ifdef DEMUX_DROP_CNT_EN
      .drop_cnt_o(dc3),
`endif
      .err_sel_o(err3));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      v4 = 1'b0; sel4 = 2'd0; dat4 = 8'h00; or4 = 4'b0000;
      v3 = 1'b0; sel3 = 2'd0; dat3 = 8'h00; or3 = 3'b000;
      #12;
      chk("rst_valid", ov4, 4'b0000);
      chk("rst_data", od4, 32'h0);
      chk("rst_err", err4, 1'b0);
      chk("rst_ready", rdy4, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // single route to channel 2
      v4 = 1'b1; sel4 = 2'd2; dat4 = 8'hA5;
      #1 chk("route_ready", rdy4, 1'b1);
      tick();
      v4 = 1'b0;
      chk("route_valid", ov4, 4'b0100);
      chk("route_data", od4, 32'h00A5_0000);

      // back-pressure on channel 1
      v4 = 1'b1; sel4 = 2'd1; dat4 = 8'h3C;
      tick();
      chk("bp_fill", ov4, 4'b0110);
      dat4 = 8'h77;
      #1 chk("bp_ready_low", rdy4, 1'b0);
      tick();
      chk("bp_hold_valid", ov4, 4'b0110);
      chk("bp_hold_data", od4[15:8], 8'h3C);
      sel4 = 2'd3; dat4 = 8'h99;
      #1 chk("bp_alt_ready", rdy4, 1'b1);
      tick();
      v4 = 1'b0;
      chk("bp_alt_valid", ov4, 4'b1110);
      chk("bp_alt_data", od4, 32'h99A5_3C00);

      // streaming into channel 0 with consumer always ready
      or4 = 4'b0001; sel4 = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         v4 = 1'b1; dat4 = 8'(i);
         #1 chk("stream_ready", rdy4, 1'b1);
         tick();
         chk("stream_valid0", ov4[0], 1'b1);
         chk("stream_data0", od4[7:0], 8'(i));
      end
      v4 = 1'b0;
      tick();
      chk("stream_drained", ov4, 4'b1110);
      chk("stream_hold", od4, 32'h99A5_3C04);
      or4 = 4'b0000;

      // out-of-range select on the 3-channel instance
      v3 = 1'b1; sel3 = 2'd0; dat3 = 8'h12;
      tick();
      chk("oor_pre_err", err3, 1'b0);
      sel3 = 2'd3; dat3 = 8'h55;
      #1 chk("oor_ready", rdy3, 1'b1);
      tick();
      v3 = 1'b0;
      chk("oor_valid", ov3, 3'b001);
      chk("oor_data", od3, 24'h00_0012);
      chk("oor_err", err3, 1'b1);
`ifdef DEMUX_DROP_CNT_EN
      chk("oor_cnt", dc3, 16'd1);
`endif
      tick();
      chk("oor_err_sticky", err3, 1'b1);
      chk("inrange_err4", err4, 1'b0);

      // fill all four channels, then reset between edges
      v4 = 1'b1; sel4 = 2'd0; dat4 = 8'h11;
      tick();
      v4 = 1'b0;
      chk("full_valid", ov4, 4'b1111);
      chk("full_data", od4, 32'h99A5_3C11);
      #1 chk("full_ready_low", rdy4, 1'b0);
      or4 = 4'b1111;
      #1 chk("full_ready_drain", rdy4, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", ov4, 4'b0000);
      chk("mid_rst_data", od4, 32'h0);
      chk("mid_rst_err3", err3, 1'b0);
`ifdef DEMUX_DROP_CNT_EN
      chk("mid_rst_cnt", dc3, 16'd0);
`endif
      tick();
      chk("mid_rst_hold", ov4, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      or4 = 4'b0000; sel4 = 2'd3;
      #1 chk("post_rst_ready", rdy4, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
